// File: rtl/data_mem_unit.sv
// Single-port data memory for the memory stage: one request at a time over valid/ready,
// with configurable wait states, byte/half/word lanes, load extension and fault reporting.
module data_mem_unit #(
  parameter int DEPTH          = 256,
  parameter int WAIT_STATES    = 0,
  parameter bit CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {INIT, IDLE, ACCESS, RESP} state_t;

  state_t state, state_next;
  logic   accept, leave;

  logic [AW-1:0] init_idx;
  logic [3:0]    wait_cnt;

  logic          we_p0, uns_p0;
  logic [1:0]    size_p0, err_p0;
  logic [AW+1:0] addr_p0;
  logic [31:0]   wdata_p0;

  logic          uns_p1, load_ok_p1;
  logic [1:0]    size_p1, off_p1, err_p1;
  logic [31:0]   word_p1;

  logic [31:0]   mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_idx;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;

  function automatic logic [1:0] check_fault(input logic [1:0] size, input logic [31:0] addr);
    logic [1:0] code;
    code = 2'b00;
    if (size == 2'b11)
      code = 2'b11;
    else if ((size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00))
      code = 2'b01;
    else if ((addr >> (AW + 2)) != 32'd0)
      code = 2'b10;
    return code;
  endfunction

  function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] lanes;
    case (size)
      2'b00:   lanes = {4{wdata[7:0]}};
      2'b01:   lanes = {2{wdata[15:0]}};
      default: lanes = wdata;
    endcase
    return lanes;
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [31:0] shifted, res;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    shifted = word >> {off, 3'b000};
    b = signed'(shifted[7:0]);
    h = signed'(off[1] ? word[31:16] : word[15:0]);
    case (size)
      2'b00:   res = uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= INIT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    leave      = 1'b0;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      INIT: begin
        if (!CLEAR_ON_RESET || init_idx == AW'(DEPTH - 1)) state_next = IDLE;
      end
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        accept    = req_valid;
        if (req_valid) state_next = ACCESS;
      end
      ACCESS: begin
        leave = (wait_cnt == 4'd0);
        if (wait_cnt == 4'd0) state_next = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = INIT;
    endcase
  end

  // Control: sweep index, wait counter, fault code and response qualifiers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_idx   <= '0;
      wait_cnt   <= 4'd0;
      err_p0     <= 2'b00;
      err_p1     <= 2'b00;
      load_ok_p1 <= 1'b0;
    end else begin
      if (state == INIT) init_idx <= init_idx + 1'b1;
      if (accept) begin
        wait_cnt <= 4'(WAIT_STATES);
        err_p0   <= check_fault(req_size, req_addr);
      end else if (state == ACCESS && wait_cnt != 4'd0) begin
        wait_cnt <= wait_cnt - 4'd1;
      end
      if (leave) begin
        err_p1     <= err_p0;
        load_ok_p1 <= !we_p0 && (err_p0 == 2'b00);
      end
    end
  end

  // Request capture (p0) and response formatting fields (p1)
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0    <= req_we;
      size_p0  <= req_size;
      uns_p0   <= req_unsigned;
      addr_p0  <= req_addr[AW+1:0];
      wdata_p0 <= req_wdata;
    end
    if (leave) begin
      size_p1 <= size_p0;
      off_p1  <= addr_p0[1:0];
      uns_p1  <= uns_p0;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = '0;
    mem_be    = 4'b0000;
    mem_wdata = 32'd0;
    if (state == INIT && CLEAR_ON_RESET) begin
      mem_we  = 1'b1;
      mem_idx = init_idx;
      mem_be  = 4'b1111;
    end else if (leave && we_p0 && err_p0 == 2'b00) begin
      mem_we    = 1'b1;
      mem_idx   = addr_p0[AW+1:2];
      mem_be    = store_be(size_p0, addr_p0[1:0]);
      mem_wdata = store_lanes(size_p0, wdata_p0);
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    if (leave && !we_p0) word_p1 <= mem[addr_p0[AW+1:2]];
  end

  assign rsp_rdata = load_ok_p1 ? load_extend(word_p1, size_p1, off_p1, uns_p1) : 32'd0;
  assign rsp_err   = err_p1;

endmodule

// File: tb/tb_data_mem_unit.sv
// Bench for data_mem_unit: three instances (W=0 clear, W=2 clear, W=2 no-clear) driven
// by scenario tasks; expected responses are queued at issue and popped on rsp_valid.
module tb_data_mem_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [2:0]       rst_n, req_valid, req_we, req_unsigned;
  logic [2:0][1:0]  req_size;
  logic [2:0][31:0] req_addr, req_wdata;
  wire  [2:0]       req_ready, rsp_valid, busy;
  wire  [2:0][1:0]  rsp_err;
  wire  [2:0][31:0] rsp_rdata;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_mem_unit #(
      .DEPTH         (g == 1 ? 16 : 256),
      .WAIT_STATES   (g == 0 ? 0 : 2),
      .CLEAR_ON_RESET(g != 2)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n[g]),
      .req_valid   (req_valid[g]),
      .req_ready   (req_ready[g]),
      .req_we      (req_we[g]),
      .req_size    (req_size[g]),
      .req_unsigned(req_unsigned[g]),
      .req_addr    (req_addr[g]),
      .req_wdata   (req_wdata[g]),
      .rsp_valid   (rsp_valid[g]),
      .rsp_rdata   (rsp_rdata[g]),
      .rsp_err     (rsp_err[g]),
      .busy        (busy[g])
    );
  end

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    logic [1:0]  err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic drive(input int d, input vec_t v);
    exp_t e;
    e.rdata = v.rd;
    e.err   = v.err;
    sb.push_back(e);
    req_we[d]       = v.we;
    req_size[d]     = v.size;
    req_unsigned[d] = v.uns;
    req_addr[d]     = v.addr;
    req_wdata[d]    = v.wdata;
  endtask

  task automatic issue(input int d, input vec_t v, output int acc, output bit ok);
    drive(d, v);
    req_valid[d] = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready[d];
      @(posedge clk);
      #1;
    end
    acc = cyc;
    req_valid[d] = 1'b0;
  endtask

  task automatic run(input int d, input vec_t v, output logic [31:0] rd, output logic [1:0] err,
                     output int lat, output bit ok);
    int acc;
    bit got;
    issue(d, v, acc, got);
    ok  = 1'b0;
    rd  = 'x;
    err = 'x;
    lat = -1;
    if (got) begin
      for (int i = 0; i < 40 && !ok; i++) begin
        @(negedge clk);
        if (rsp_valid[d]) begin
          ok  = 1'b1;
          rd  = rsp_rdata[d];
          err = rsp_err[d];
          lat = cyc - acc;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    logic [1:0]  err;
    int lat, n;
    bit ok;
    exp_t e;
    rst_n = '0; req_valid = '0; req_we = '0; req_unsigned = '0;
    req_size = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0], busy[0]} !== {1'b0, 1'b0, 32'd0, 2'b00, 1'b1}) begin
      failures++;
      $display("FAIL reset_values: got ready=%b valid=%b rdata=%h err=%b busy=%b want 0 0 00000000 00 1",
               req_ready[0], rsp_valid[0], rsp_rdata[0], rsp_err[0], busy[0]);
    end
    @(posedge clk);
    #1;
    rst_n = '1;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy[0]) break;
      n++;
    end
    checks++;
    if (n !== 256) begin
      failures++;
      $display("FAIL sweep_len: got busy for %0d cycles want 256", n);
    end
    run(0, '{1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 32'h0, 2'd0}, rd, err, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || {rd, err} !== {e.rdata, e.err}) begin
      failures++;
      $display("FAIL sweep_lw3fc: got rdata=%h err=%b want rdata=%h err=%b", rd, err, e.rdata, e.err);
    end
  endtask

  task automatic test_extension();
    vec_t t [5] = '{
      '{1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        2'd0},
      '{1'b0, 2'd0, 1'b0, 32'h13, 32'h0,        32'hFFFFFFDE, 2'd0},
      '{1'b0, 2'd0, 1'b1, 32'h13, 32'h0,        32'h000000DE, 2'd0},
      '{1'b0, 2'd1, 1'b0, 32'h10, 32'h0,        32'hFFFFBEEF, 2'd0},
      '{1'b0, 2'd1, 1'b1, 32'h12, 32'h0,        32'h0000DEAD, 2'd0}};
    logic [31:0] rd;
    logic [1:0]  err;
    int lat;
    bit ok;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      run(0, t[i], rd, err, lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || {rd, err} !== {e.rdata, e.err}) begin
        failures++;
        $display("FAIL ext[%0d]: got rdata=%h err=%b want rdata=%h err=%b", i, rd, err, e.rdata, e.err);
      end
      checks++;
      if (lat !== 1) begin
        failures++;
        $display("FAIL ext_lat[%0d]: got rsp %0d edges after accept want 1", i, lat);
      end
    end
  endtask

  task automatic test_byte_lanes();
    vec_t t [3] = '{
      '{1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF55, 32'h0,        2'd0},
      '{1'b1, 2'd1, 1'b0, 32'h12, 32'hFFFF1234, 32'h0,        2'd0},
      '{1'b0, 2'd2, 1'b0, 32'h10, 32'h0,        32'h123455EF, 2'd0}};
    logic [31:0] rd;
    logic [1:0]  err;
    int lat;
    bit ok;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      run(0, t[i], rd, err, lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || {rd, err} !== {e.rdata, e.err}) begin
        failures++;
        $display("FAIL lanes[%0d]: got rdata=%h err=%b want rdata=%h err=%b", i, rd, err, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_faults();
    vec_t t [9] = '{
      '{1'b1, 2'd2, 1'b0, 32'h0,   32'hA5A5A5A5, 32'h0,        2'd0},
      '{1'b0, 2'd2, 1'b0, 32'h12,  32'h0,        32'h0,        2'd1},
      '{1'b1, 2'd1, 1'b0, 32'h401, 32'h0000BBBB, 32'h0,        2'd1},
      '{1'b1, 2'd2, 1'b0, 32'h400, 32'h11111111, 32'h0,        2'd2},
      '{1'b0, 2'd2, 1'b0, 32'h0,   32'h0,        32'hA5A5A5A5, 2'd0},
      '{1'b0, 2'd3, 1'b0, 32'h0,   32'h0,        32'h0,        2'd3},
      '{1'b1, 2'd3, 1'b0, 32'h0,   32'h22222222, 32'h0,        2'd3},
      '{1'b0, 2'd0, 1'b0, 32'h400, 32'h0,        32'h0,        2'd2},
      '{1'b0, 2'd2, 1'b0, 32'h0,   32'h0,        32'hA5A5A5A5, 2'd0}};
    logic [31:0] rd;
    logic [1:0]  err;
    int lat;
    bit ok;
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      run(0, t[i], rd, err, lat, ok);
      e = sb.pop_front();
      checks++;
      if (!ok || {rd, err} !== {e.rdata, e.err}) begin
        failures++;
        $display("FAIL fault[%0d]: got rdata=%h err=%b want rdata=%h err=%b", i, rd, err, e.rdata, e.err);
      end
      checks++;
      if (lat !== 1) begin
        failures++;
        $display("FAIL fault_lat[%0d]: got rsp %0d edges after accept want 1", i, lat);
      end
    end
  endtask

  task automatic test_back_to_back();
    vec_t t [3] = '{
      '{1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h13579BDF, 2'd0},
      '{1'b0, 2'd0, 1'b0, 32'h9, 32'h0, 32'hFFFFFF9B, 2'd0},
      '{1'b0, 2'd2, 1'b0, 32'h3, 32'h0, 32'h0,        2'd1}};
    int acc [3] = '{-100, -100, -100};
    int rsp [3] = '{-100, -100, -100};
    int na = 0, nr = 0, lat;
    bit a, ok;
    logic [31:0] rd;
    logic [1:0]  err;
    exp_t e;
    run(1, '{1'b1, 2'd2, 1'b0, 32'h8, 32'h13579BDF, 32'h0, 2'd0}, rd, err, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || {rd, err} !== {e.rdata, e.err} || lat !== 3) begin
      failures++;
      $display("FAIL w2_store: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=3", rd, err, lat, e.rdata, e.err);
    end
    drive(1, t[0]);
    req_valid[1] = 1'b1;
    for (int i = 0; i < 60 && nr < 3; i++) begin
      @(negedge clk);
      if (rsp_valid[1] && sb.size() > 0) begin
        rsp[nr] = cyc;
        e = sb.pop_front();
        checks++;
        if ({rsp_rdata[1], rsp_err[1]} !== {e.rdata, e.err}) begin
          failures++;
          $display("FAIL b2b_rsp[%0d]: got rdata=%h err=%b want rdata=%h err=%b",
                   nr, rsp_rdata[1], rsp_err[1], e.rdata, e.err);
        end
        nr++;
      end
      a = req_ready[1] && req_valid[1];
      @(posedge clk);
      #1;
      if (a) begin
        acc[na] = cyc;
        na++;
        if (na < 3) drive(1, t[na]);
        else req_valid[1] = 1'b0;
      end
    end
    req_valid[1] = 1'b0;
    checks++;
    if (nr !== 3) begin
      failures++;
      $display("FAIL b2b_count: got %0d responses want 3", nr);
    end
    checks++;
    if (acc[1] - acc[0] !== 5 || acc[2] - acc[0] !== 10) begin
      failures++;
      $display("FAIL b2b_accept: got accepts at k+%0d,k+%0d want k+5,k+10", acc[1] - acc[0], acc[2] - acc[0]);
    end
    checks++;
    if (rsp[0] - acc[0] !== 3 || rsp[1] - acc[0] !== 8) begin
      failures++;
      $display("FAIL b2b_rsp_timing: got pulses after k+%0d,k+%0d want k+3,k+8", rsp[0] - acc[0], rsp[1] - acc[0]);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd;
    logic [1:0]  err;
    int lat, acc;
    bit ok, seen;
    exp_t e;
    run(2, '{1'b1, 2'd2, 1'b0, 32'h20, 32'h0BADC0DE, 32'h0, 2'd0}, rd, err, lat, ok);
    e = sb.pop_front();
    run(2, '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0BADC0DE, 2'd0}, rd, err, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || {rd, err} !== {e.rdata, e.err}) begin
      failures++;
      $display("FAIL abort_pre: got rdata=%h err=%b want rdata=%h err=%b", rd, err, e.rdata, e.err);
    end
    issue(2, '{1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0, 2'd0}, acc, ok);
    e = sb.pop_back();
    @(posedge clk);
    #1;
    rst_n[2] = 1'b0;
    @(negedge clk);
    seen = rsp_valid[2];
    @(posedge clk);
    #1;
    rst_n[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen |= rsp_valid[2];
    end
    checks++;
    if (!ok || seen !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_rsp: got accepted=%b rsp_seen=%b want accepted=1 rsp_seen=0", ok, seen);
    end
    run(2, '{1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0BADC0DE, 2'd0}, rd, err, lat, ok);
    e = sb.pop_front();
    checks++;
    if (!ok || {rd, err} !== {e.rdata, e.err} || lat !== 3) begin
      failures++;
      $display("FAIL abort_post: got rdata=%h err=%b lat=%0d want rdata=%h err=%b lat=3", rd, err, lat, e.rdata, e.err);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_extension();
    test_byte_lanes();
    test_faults();
    test_back_to_back();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
